df_mid_lsdc_allocq13: RTL
=========================

DF_MID_LSDC_ALLOCQ13 -- requirements
Module: df_mid_lsdc_allocq13

Interface
REQ-001 SHALL have parameter SIZE, default 8, number of tracked entries (2..64).
REQ-002 SHALL have parameter ALLOC, default 4, allocation ports per cycle (1..SIZE).
REQ-003 SHALL have port Clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port AllocReq  input  ALLOC  per-port request; bit 0 is oldest in age order.
REQ-006 SHALL have port DeallocEn  input  SIZE  entries to free this cycle.
REQ-007 SHALL have port AllocIdx  output  ALLOC*SIZE  registered one-hot granted index per port, packed [ALLOC-1:0][SIZE-1:0].
REQ-008 SHALL have port AllocVal  output  ALLOC  registered grant valid per port.
REQ-009 SHALL have port Valid  output  SIZE  registered occupied-entry vector.
REQ-010 SHALL have port FreeCnt  output  $clog2(SIZE+1)  registered count of unoccupied entries.
REQ-011 SHALL have port Full  output  1  FreeCnt==0.
REQ-012 SHALL have port Empty  output  1  FreeCnt==SIZE.
REQ-013 SHALL have port DeallocErr  output  1  sticky flag, dealloc of a non-valid entry seen.

Function
REQ-014 Grant selection SHALL use the current registered Valid only; entries freed this cycle are not grantable until the next cycle.
REQ-015 Set request bits SHALL be ranked by ascending port index; the k-th set request (k from 0) SHALL receive the k-th free entry in search order.
REQ-016 If fewer free entries than set requests exist, the lowest-ranked requests SHALL be granted and all remaining requests dropped (AllocVal=0); no request is queued.
REQ-017 Grant latency SHALL be 1 cycle: request in cycle N -> AllocIdx/AllocVal valid in cycle N+1; Valid bit set in cycle N+1.
REQ-018 Ports with AllocVal=0 SHALL drive AllocIdx all zeros.
REQ-019 Granted indices within one cycle SHALL be mutually distinct and SHALL never select a Valid entry.
REQ-020 Next Valid SHALL be (Valid & ~DeallocEn) | granted-mask.
REQ-021 DeallocEn bits on non-valid entries SHALL be ignored for Valid and SHALL set DeallocErr.
REQ-022 Dealloc and grant of the same index in one cycle cannot occur (REQ-014); Valid SHALL show the new owner only via the grant.
REQ-023 FreeCnt SHALL equal SIZE minus popcount(Valid) every cycle; it SHALL never underflow or exceed SIZE.
REQ-024 AllocReq=0 and DeallocEn=0 SHALL hold all state and deassert AllocVal next cycle.

Reset
REQ-025 Reset SHALL dominate all inputs in the same cycle.
REQ-026 On reset: Valid=0, AllocVal=0, AllocIdx=0, FreeCnt=SIZE, Full=0, Empty=1, DeallocErr=0, rotate pointer=0.
REQ-027 Reset asserted mid-allocation SHALL drop in-flight requests; no grant appears in the cycle after reset.

Configuration
REQ-028 Macro DF_MID_LSDC_ALLOCQ_ROTATE_EN SHALL select the free-entry search order.
REQ-029 Without the macro, search SHALL start at index 0 ascending (lowest-free-first).
REQ-030 With the macro, search SHALL start at a registered pointer, ascending with wrap from SIZE-1 to 0; the pointer SHALL advance to (last granted index + 1) mod SIZE on any cycle with at least one grant, else hold.

Verification
REQ-031 Reset, then AllocReq=4'b0011 -> next cycle AllocVal=4'b0011, AllocIdx[0]=8'h01, AllocIdx[1]=8'h02, Valid=8'h03, FreeCnt=6.
REQ-032 Valid=8'hFD, AllocReq=4'b1111 -> only port 0 granted, AllocIdx[0]=8'h02, AllocVal=4'b0001, Full=1.
REQ-033 Valid=8'hFF, DeallocEn=8'h10, AllocReq=4'b0001 same cycle -> no grant, Valid=8'hEF; retry next cycle -> AllocIdx[0]=8'h10.
REQ-034 Valid=8'h00, DeallocEn=8'h04 -> DeallocErr=1, stays 1 until Reset, Valid unchanged.
REQ-035 AllocReq=4'b1010 on empty queue -> AllocIdx[1]=8'h01, AllocIdx[3]=8'h02, ports 0/2 AllocVal=0 with AllocIdx=0.
REQ-036 With DF_MID_LSDC_ALLOCQ_ROTATE_EN: grant idx 0,1, free both, AllocReq=4'b0001 -> AllocIdx[0]=8'h04; Reset asserted with AllocReq=4'b1111 -> next cycle AllocVal=0, Valid=0.

Source files
------------

// File: rtl/df_mid_lsdc_allocq13.sv
// Allocation queue: grants up to ALLOC free entries per cycle out of SIZE tracked slots.
// Define DF_MID_LSDC_ALLOCQ_ROTATE_EN to search from a rotating pointer instead of index 0.
module df_mid_lsdc_allocq13 #(
    parameter int SIZE  = 8,
    parameter int ALLOC = 4
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [ALLOC-1:0]                 AllocReq,
    input  logic [SIZE-1:0]                  DeallocEn,
    output logic [ALLOC-1:0][SIZE-1:0]       AllocIdx,
    output logic [ALLOC-1:0]                 AllocVal,
    output logic [SIZE-1:0]                  Valid,
    output logic [$clog2(SIZE+1)-1:0]        FreeCnt,
    output logic                             Full,
    output logic                             Empty,
    output logic                             DeallocErr
);

    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE+1);
    localparam logic [PW:0] SIZE_P = (PW+1)'(SIZE);

    logic [SIZE-1:0]            valid_q;
    logic [ALLOC-1:0][SIZE-1:0] alloc_idx_q;
    logic [ALLOC-1:0]           alloc_val_q;
    logic [CW-1:0]              free_cnt_q;
    logic                       err_q;
    logic [PW-1:0]              start_ptr;

    logic [ALLOC-1:0][SIZE-1:0] grant_idx;
    logic [ALLOC-1:0]           grant_val;
    logic [SIZE-1:0]            grant_mask;
    logic [SIZE-1:0]            valid_next;
    logic [CW-1:0]              free_next;
    logic                       err_next;

    function automatic logic [PW-1:0] wrap_pos(input logic [PW-1:0] base, input int unsigned ofs);
        logic [PW:0] pos;
        pos = {1'b0, base} + (PW+1)'(ofs);
        if (pos >= SIZE_P)
            pos = pos - SIZE_P;
        return pos[PW-1:0];
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [SIZE-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < SIZE; i++)
            cnt = cnt + CW'(v[i]);
        return cnt;
    endfunction

    // Each set request, in port order, takes the next still-free slot in search order.
    // Only the registered Valid is consulted, so slots freed this cycle are not reused yet.
    always_comb begin
        logic [SIZE-1:0] avail;
        logic [PW-1:0]   idx;
        logic            found;
        avail      = ~valid_q;
        grant_idx  = '0;
        grant_val  = '0;
        grant_mask = '0;
        idx        = '0;
        found      = 1'b0;
        for (int p = 0; p < ALLOC; p++) begin
            found = 1'b0;
            if (AllocReq[p]) begin
                for (int j = 0; j < SIZE; j++) begin
                    idx = wrap_pos(start_ptr, j);
                    if (!found && avail[idx]) begin
                        found              = 1'b1;
                        avail[idx]         = 1'b0;
                        grant_idx[p][idx]  = 1'b1;
                        grant_mask[idx]    = 1'b1;
                    end
                end
            end
            grant_val[p] = found;
        end
    end

    always_comb begin
        valid_next = (valid_q & ~DeallocEn) | grant_mask;
        free_next  = CW'(SIZE) - popcount(valid_next);
        err_next   = err_q | (|(DeallocEn & ~valid_q));
    end

`ifdef DF_MID_LSDC_ALLOCQ_ROTATE_EN
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] last_idx;
    logic [PW-1:0] scan_idx;

    // The last grant in search order is the furthest slot reached; resume just past it.
    always_comb begin
        last_idx = ptr_q;
        scan_idx = '0;
        for (int j = 0; j < SIZE; j++) begin
            scan_idx = wrap_pos(ptr_q, j);
            if (grant_mask[scan_idx])
                last_idx = scan_idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            ptr_q <= '0;
        else if (|grant_mask)
            ptr_q <= wrap_pos(last_idx, 1);
    end

    assign start_ptr = ptr_q;
`else
    assign start_ptr = '0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q     <= '0;
            alloc_idx_q <= '0;
            alloc_val_q <= '0;
            free_cnt_q  <= CW'(SIZE);
            err_q       <= 1'b0;
        end else begin
            valid_q     <= valid_next;
            alloc_idx_q <= grant_idx;
            alloc_val_q <= grant_val;
            free_cnt_q  <= free_next;
            err_q       <= err_next;
        end
    end

    assign AllocIdx   = alloc_idx_q;
    assign AllocVal   = alloc_val_q;
    assign Valid      = valid_q;
    assign FreeCnt    = free_cnt_q;
    assign Full       = (free_cnt_q == '0);
    assign Empty      = (free_cnt_q == CW'(SIZE));
    assign DeallocErr = err_q;

endmodule
